// File: rtl/mem_port_arbiter_if.sv
// Request/response signals of the fetch and load/store ports plus the byte-serial memory bus.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_res;

    logic        data_valid;
    logic        data_wr;
    logic [2:0]  data_type;
    logic [31:0] data_addr;
    logic [31:0] data_value;
    logic        data_ready;
    logic [31:0] data_res;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  inst_valid, inst_addr,
        output inst_ready, inst_res,
        input  data_valid, data_wr, data_type, data_addr, data_value,
        output data_ready, data_res,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output inst_valid, inst_addr,
        input  inst_ready, inst_res,
        output data_valid, data_wr, data_type, data_addr, data_value,
        input  data_ready, data_res,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto a byte-serial memory bus,
// splitting each access into sequential byte transactions with the 1-cycle read latency pipelined.
module mem_port_arbiter #(
    parameter logic [1:0] IO_SEL     = 2'b11,
    parameter bit         DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              io_buffer_full,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        INST_RD,
        DATA_RD,
        DATA_WR,
        DONE
    } state_t;

    state_t      state, state_next;

    logic [2:0]  cnt, cnt_next;
    logic [2:0]  len, len_next;
    logic [31:0] addr_q, addr_next;
    logic [31:0] value_q, value_next;
    logic [2:0]  type_q, type_next;
    logic        io_q, io_next;
    logic [31:0] buf_q, buf_next;

    logic [31:0] mem_a_q, mem_a_next;
    logic        mem_wr_q, mem_wr_next;
    logic [7:0]  mem_dout_q, mem_dout_next;
    logic        inst_ready_q, inst_ready_next;
    logic        data_ready_q, data_ready_next;
    logic [31:0] inst_res_q, inst_res_next;
    logic [31:0] data_res_q, data_res_next;

    logic        inst_req;
    logic        accept_data;
    logic        accept_inst;
    logic [2:0]  cnt_inc;
    logic [31:0] addr_inc;
    logic [1:0]  byte_idx;
    logic [31:0] buf_merged;
    logic        rd_last;
    logic        wr_last;
    logic        wr_block;

    function automatic logic [2:0] size_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] t);
        case (t[1:0])
            2'b00:   return t[2] ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   return t[2] ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    // A flushed fetch is never accepted; ties go to the port selected by DATA_FIRST.
    assign inst_req    = bus.inst_valid && !clear;
    assign accept_data = bus.data_valid && (DATA_FIRST || !inst_req);
    assign accept_inst = inst_req && !accept_data;

    assign cnt_inc  = cnt + 3'd1;
    assign addr_inc = addr_q + {29'd0, cnt_inc};
    assign byte_idx = cnt[1:0] - 2'd1;
    assign rd_last  = (cnt == len);
    assign wr_last  = mem_wr_q && (cnt == len - 3'd1);
    assign wr_block = io_q && io_buffer_full;

    // Byte cnt-1 arrives on mem_din one cycle after its address was presented.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[{byte_idx, 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            len          <= 3'd0;
            addr_q       <= 32'd0;
            value_q      <= 32'd0;
            type_q       <= 3'd0;
            io_q         <= 1'b0;
            buf_q        <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_wr_q     <= 1'b0;
            mem_dout_q   <= 8'd0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_res_q   <= 32'd0;
            data_res_q   <= 32'd0;
        end else if (rdy) begin
            state        <= state_next;
            cnt          <= cnt_next;
            len          <= len_next;
            addr_q       <= addr_next;
            value_q      <= value_next;
            type_q       <= type_next;
            io_q         <= io_next;
            buf_q        <= buf_next;
            mem_a_q      <= mem_a_next;
            mem_wr_q     <= mem_wr_next;
            mem_dout_q   <= mem_dout_next;
            inst_ready_q <= inst_ready_next;
            data_ready_q <= data_ready_next;
            inst_res_q   <= inst_res_next;
            data_res_q   <= data_res_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_data)
                    state_next = bus.data_wr ? DATA_WR : DATA_RD;
                else if (accept_inst)
                    state_next = INST_RD;
            end
            INST_RD, DATA_RD: begin
                if (clear)
                    state_next = IDLE;
                else if (rd_last)
                    state_next = DONE;
            end
            DATA_WR: begin
                if (wr_last)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stores ignore clear: once accepted they are committed and must finish.
    always_comb begin
        cnt_next        = cnt;
        len_next        = len;
        addr_next       = addr_q;
        value_next      = value_q;
        type_next       = type_q;
        io_next         = io_q;
        buf_next        = buf_q;
        mem_a_next      = mem_a_q;
        mem_wr_next     = mem_wr_q;
        mem_dout_next   = mem_dout_q;
        inst_ready_next = inst_ready_q;
        data_ready_next = data_ready_q;
        inst_res_next   = inst_res_q;
        data_res_next   = data_res_q;
        case (state)
            IDLE: begin
                if (accept_data) begin
                    addr_next     = bus.data_addr;
                    value_next    = bus.data_value;
                    type_next     = bus.data_type;
                    len_next      = size_len(bus.data_type[1:0]);
                    io_next       = (bus.data_addr[17:16] == IO_SEL);
                    cnt_next      = 3'd0;
                    buf_next      = 32'd0;
                    mem_a_next    = bus.data_addr;
                    mem_dout_next = bus.data_value[7:0];
                    mem_wr_next   = bus.data_wr &&
                                    !((bus.data_addr[17:16] == IO_SEL) && io_buffer_full);
                end else if (accept_inst) begin
                    addr_next   = bus.inst_addr;
                    type_next   = 3'b010;
                    len_next    = 3'd4;
                    io_next     = 1'b0;
                    cnt_next    = 3'd0;
                    buf_next    = 32'd0;
                    mem_a_next  = bus.inst_addr;
                    mem_wr_next = 1'b0;
                end
            end
            INST_RD, DATA_RD: begin
                if (clear) begin
                    cnt_next    = 3'd0;
                    mem_a_next  = 32'd0;
                    mem_wr_next = 1'b0;
                end else begin
                    cnt_next   = cnt_inc;
                    mem_a_next = (cnt_inc < len) ? addr_inc : 32'd0;
                    if (cnt != 3'd0)
                        buf_next = buf_merged;
                    if (rd_last) begin
                        cnt_next = 3'd0;
                        if (state == INST_RD) begin
                            inst_res_next   = buf_merged;
                            inst_ready_next = 1'b1;
                        end else begin
                            data_res_next   = extend(buf_merged, type_q);
                            data_ready_next = 1'b1;
                        end
                    end
                end
            end
            DATA_WR: begin
                if (mem_wr_q) begin
                    if (wr_last) begin
                        mem_wr_next     = 1'b0;
                        mem_a_next      = 32'd0;
                        cnt_next        = 3'd0;
                        data_res_next   = 32'd0;
                        data_ready_next = 1'b1;
                    end else begin
                        cnt_next      = cnt_inc;
                        mem_a_next    = addr_inc;
                        mem_dout_next = value_q[{cnt_inc[1:0], 3'b000} +: 8];
                        mem_wr_next   = !wr_block;
                    end
                end else begin
                    mem_wr_next = !wr_block;
                end
            end
            DONE: begin
                inst_ready_next = 1'b0;
                data_ready_next = 1'b0;
            end
            default: begin
                cnt_next = cnt;
            end
        endcase
    end

    // A flush arriving during the DONE cycle cancels the fetch result the core would otherwise take.
    assign bus.inst_ready = inst_ready_q && !clear;
    assign bus.inst_res   = inst_res_q;
    assign bus.data_ready = data_ready_q;
    assign bus.data_res   = data_res_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_dout   = mem_dout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios followed by random loads/stores against a byte-array memory model.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic rdy;
    logic clear;
    logic io_buffer_full;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem     [bit [31:0]];
    logic [7:0] ref_mem [bit [31:0]];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .IO_SEL     (2'b11),
        .DATA_FIRST (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clear          (clear),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a))
            return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic int len_of(input logic [2:0] t);
        if (t[1:0] == 2'b00)
            return 1;
        if (t[1:0] == 2'b01)
            return 2;
        return 4;
    endfunction

    // Little-endian gather of n bytes, then sign or zero extension of the narrow results.
    function automatic logic [31:0] expect_load(input logic [31:0] addr, input int n, input logic [2:0] t);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++)
            w[8*k +: 8] = ref_rd(addr + 32'(k));
        if (n == 1 && !t[2])
            w = {{24{w[7]}}, w[7:0]};
        if (n == 2 && !t[2])
            w = {{16{w[15]}}, w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            2:       return 32'h0003_0000 + 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // The memory answers the previous cycle's address and shares the global ready with the core.
    always @(posedge clk) begin
        if (rst) begin
            bus.mem_din <= 8'd0;
        end else if (rdy) begin
            bus.mem_din <= bus_rd(bus.mem_a);
            if (bus.mem_wr)
                mem[bus.mem_a] = bus.mem_dout;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_a"}, bus.mem_a, 32'd0);
        check_output({tag, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
        check_output({tag, "_rdy"}, {30'd0, bus.inst_ready, bus.data_ready}, 32'd0);
    endtask

    // Load or fetch: optional 2-cycle rdy stall at cycle stall_at, optional clear at cycle clear_at
    // (clear_at == n+2 raises clear during the ready cycle only).
    task automatic apply_load(input bit inst, input logic [31:0] addr, input logic [2:0] dtype,
                              input int stall_at, input int clear_at);
        int n;
        int live;
        int j;
        int stalls;
        logic [31:0] expv;
        string nm;
        n    = inst ? 4 : len_of(dtype);
        expv = expect_load(addr, n, inst ? 3'b010 : dtype);
        nm   = inst ? "ird" : "ld";
        if (inst) begin
            bus.inst_valid = 1'b1;
            bus.inst_addr  = addr;
        end else begin
            bus.data_valid = 1'b1;
            bus.data_wr    = 1'b0;
            bus.data_type  = dtype;
            bus.data_addr  = addr;
            bus.data_value = $urandom;
        end
        live   = 0;
        stalls = 0;
        while (live <= n) begin
            @(negedge clk);
            j = live + 1;
            check_output({nm, "_addr"}, bus.mem_a, (j <= n) ? addr + 32'(j - 1) : 32'd0);
            check_output({nm, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
            check_output({nm, "_early"}, {30'd0, bus.inst_ready, bus.data_ready}, 32'd0);
            if (j == clear_at) begin
                clear = 1'b1;
                rdy   = 1'b1;
                if (inst) bus.inst_valid = 1'b0;
                else      bus.data_valid = 1'b0;
                @(negedge clk);
                clear = 1'b0;
                check_quiet({nm, "_flush"});
                @(negedge clk);
                check_quiet({nm, "_flush_idle"});
                return;
            end
            if (j == stall_at && stalls < 2) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = 1'b1;
            end
            if (rdy)
                live++;
        end
        @(negedge clk);
        if (inst) begin
            check_output("ird_ready", {31'd0, bus.inst_ready}, 32'd1);
            check_output("ird_res", bus.inst_res, expv);
            check_output("ird_other", {31'd0, bus.data_ready}, 32'd0);
            if (clear_at == n + 2) begin
                clear = 1'b1;
                #1;
                check_output("ird_done_flush", {31'd0, bus.inst_ready}, 32'd0);
                clear = 1'b0;
            end
            bus.inst_valid = 1'b0;
        end else begin
            check_output("ld_ready", {31'd0, bus.data_ready}, 32'd1);
            check_output("ld_res", bus.data_res, expv);
            check_output("ld_other", {31'd0, bus.inst_ready}, 32'd0);
            bus.data_valid = 1'b0;
        end
        @(negedge clk);
        check_quiet({nm, "_after"});
    endtask

    // Store: io_buffer_full high for the first full_edges edges; optional clear at cycle clear_at.
    task automatic apply_store(input logic [31:0] addr, input logic [31:0] value, input logic [2:0] dtype,
                               input int full_edges, input int clear_at);
        int n;
        int fe;
        int k;
        n  = len_of(dtype);
        fe = (addr[17:16] == 2'b11) ? full_edges : 0;
        for (int b = 0; b < n; b++)
            ref_mem[addr + 32'(b)] = value[8*b +: 8];
        bus.data_valid = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_type  = dtype;
        bus.data_addr  = addr;
        bus.data_value = value;
        io_buffer_full = (full_edges > 0);
        for (int j = 1; j <= fe + n + 1; j++) begin
            @(negedge clk);
            if (j <= fe) begin
                check_output("st_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
                check_output("st_stall_rdy", {31'd0, bus.data_ready}, 32'd0);
            end else if (j <= fe + n) begin
                k = j - fe - 1;
                check_output("st_wr", {31'd0, bus.mem_wr}, 32'd1);
                check_output("st_addr", bus.mem_a, addr + 32'(k));
                check_output("st_byte", {24'd0, bus.mem_dout}, {24'd0, value[8*k +: 8]});
                check_output("st_early", {31'd0, bus.data_ready}, 32'd0);
            end else begin
                check_output("st_ready", {31'd0, bus.data_ready}, 32'd1);
                check_output("st_res", bus.data_res, 32'd0);
                check_output("st_end_wr", {31'd0, bus.mem_wr}, 32'd0);
                check_output("st_end_a", bus.mem_a, 32'd0);
            end
            io_buffer_full = (j < full_edges);
            clear          = (j == clear_at);
        end
        bus.data_valid = 1'b0;
        io_buffer_full = 1'b0;
        clear          = 1'b0;
        @(negedge clk);
        check_quiet("st_after");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        int          n;
        $display("[TB] mem_port_arbiter bench start");
        rst            = 1'b1;
        rdy            = 1'b1;
        clear          = 1'b0;
        io_buffer_full = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst_addr  = 32'd0;
        bus.data_valid = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_type  = 3'd0;
        bus.data_addr  = 32'd0;
        bus.data_value = 32'd0;
        #12;
        check_output("rst_a", bus.mem_a, 32'd0);
        check_output("rst_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_output("rst_dout", {24'd0, bus.mem_dout}, 32'd0);
        check_output("rst_rdy", {30'd0, bus.inst_ready, bus.data_ready}, 32'd0);
        check_output("rst_ires", bus.inst_res, 32'd0);
        check_output("rst_dres", bus.data_res, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // A fetch raised together with clear must not start.
        bus.inst_valid = 1'b1;
        bus.inst_addr  = 32'h100;
        clear          = 1'b1;
        @(negedge clk);
        check_output("clear_idle_a", bus.mem_a, 32'd0);
        bus.inst_valid = 1'b0;
        clear          = 1'b0;
        @(negedge clk);

        mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
        ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
        mem[32'h20] = 8'h80;
        ref_mem[32'h20] = 8'h80;

        apply_load(1'b1, 32'h100, 3'b010, 0, 0);
        check_output("ird_word", bus.inst_res, 32'h0000_0513);
        apply_load(1'b0, 32'h20, 3'b000, 0, 0);
        check_output("lb_signed", bus.data_res, 32'hFFFF_FF80);
        apply_load(1'b0, 32'h20, 3'b100, 0, 0);
        check_output("lbu_zero", bus.data_res, 32'h0000_0080);

        apply_store(32'h40, 32'hDEAD_BEEF, 3'b010, 0, 0);
        apply_load(1'b0, 32'h40, 3'b010, 0, 0);
        check_output("lw_back", bus.data_res, 32'hDEAD_BEEF);

        // Simultaneous requests: data first, then the waiting fetch.
        bus.inst_valid = 1'b1;
        bus.inst_addr  = 32'h100;
        apply_load(1'b0, 32'h40, 3'b001, 0, 0);
        apply_load(1'b1, 32'h100, 3'b010, 0, 0);

        apply_store(32'h0003_0000, 32'h0000_0041, 3'b000, 3, 0);
        apply_load(1'b1, 32'h100, 3'b010, 0, 2);
        apply_store(32'h60, 32'h0000_A55A, 3'b001, 0, 1);
        apply_load(1'b0, 32'h60, 3'b001, 0, 0);
        apply_load(1'b1, 32'h100, 3'b010, 3, 0);
        apply_load(1'b1, 32'h100, 3'b010, 0, 6);
        apply_load(1'b1, 32'hFFFF_FFFE, 3'b010, 0, 0);

        // Asynchronous reset in the middle of a store.
        bus.data_valid = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_type  = 3'b010;
        bus.data_addr  = 32'h5000;
        bus.data_value = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        check_output("mid_wr", {31'd0, bus.mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("arst_a", bus.mem_a, 32'd0);
        check_output("arst_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_output("arst_dout", {24'd0, bus.mem_dout}, 32'd0);
        bus.data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("arst_idle");

        for (int i = 0; i < 40; i++) begin
            a = rand_addr();
            t = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            case ($urandom_range(0, 2))
                0: apply_load(1'b1, a, 3'b010,
                              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
                              ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0);
                1: begin
                    n = len_of(t);
                    apply_load(1'b0, a, t,
                               ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + 1) : 0,
                               ($urandom_range(0, 5) == 0) ? $urandom_range(1, n + 1) : 0);
                end
                default: begin
                    n = len_of(t);
                    apply_store(a, $urandom, t, $urandom_range(0, 3),
                                ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
